bitmap_index_encoder: RTL and testbench

- Sequential encoder, the inverse direction of the team's binary-to-one-hot decoders.
- Accepts an N-bit bitmap (e.g. one row of live cells from the game-of-life grid) and emits the index of every set bit, LSB first, one per cycle over a valid/ready stream.
- Sits between the cell array and any consumer that needs cell coordinates: display, logging, or a decoder driving a write-enable.

---
 rtl/bitmap_index_encoder.sv | 103 ++++++++++
 tb/tb_bitmap_index_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_index_encoder.sv
// Bitmap index encoder: accepts an N-bit bitmap and streams out the index of
// every set bit, lowest first, one per cycle over a valid/ready handshake.
// An all-zero bitmap produces a single empty_pulse instead of any indices.
module bitmap_index_encoder #(
   parameter int N = 16,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] load_bits,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_index,
   output logic         out_last,
   output logic         empty_pulse,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EMIT  = 2'd1,
      EMPTY = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   pending_minus_one;
   logic [W-1:0]   lowest_index;
   logic           single_bit;

   // Find the lowest set bit of the pending bitmap (0 when nothing is pending).
   always_comb begin
      lowest_index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            lowest_index = W'(i);
         end
      end
   end

   assign pending_minus_one = pending_q - N'(1);
   assign single_bit        = ((pending_q & pending_minus_one) == '0);

   // Every output is decoded from registered state only, so nothing on the
   // load or consumer side can ripple combinationally to the outputs.
   always_comb begin
      load_ready  = (state_q == IDLE);
      out_valid   = (state_q == EMIT);
      busy        = (state_q != IDLE);
      empty_pulse = (state_q == EMPTY);
      out_index   = lowest_index;
      out_last    = (state_q == EMIT) && single_bit;
   end

   // Next-state logic; clear overrides any load or handshake in the same cycle.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      if (clear) begin
         state_d   = IDLE;
         pending_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (load_valid) begin
                  pending_d = load_bits;
                  state_d   = (load_bits != '0) ? EMIT : EMPTY;
               end
            end
            EMPTY: begin
               state_d = IDLE;
            end
            EMIT: begin
               if (out_ready) begin
                  pending_d = pending_q & pending_minus_one;
                  if (single_bit) begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d   = IDLE;
               pending_d = '0;
            end
         endcase
      end
   end

   // State and pending-bitmap registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

endmodule

// File: tb/tb_bitmap_index_encoder.sv
// Self-checking bench for bitmap_index_encoder (N=16): directed scenarios
// followed by randomized bitmaps with random backpressure, all compared
// against a queue of expected indices derived from the loaded bitmap.
module tb_bitmap_index_encoder;

   localparam int N = 16;
   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         clear;
   logic         load_valid;
   logic         load_ready;
   logic [N-1:0] load_bits;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_index;
   logic         out_last;
   logic         empty_pulse;
   logic         busy;

   int errors;
   int checks;
   int exp_q[$];

   // Observed output bundle: {out_valid, load_ready, busy, empty_pulse, out_last, out_index}
   logic [8:0] obs;
   assign obs = {out_valid, load_ready, busy, empty_pulse, out_last, out_index};

   localparam logic [8:0] IDLE_EXP  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
   localparam logic [8:0] EMPTY_EXP = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};

   bitmap_index_encoder #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_bits   (load_bits),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_index   (out_index),
      .out_last    (out_last),
      .empty_pulse (empty_pulse),
      .busy        (busy)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected emission order: every set bit position, lowest first.
   function automatic void build_model(input logic [N-1:0] b);
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         if (b[i]) exp_q.push_back(i);
      end
   endfunction

   function automatic logic [8:0] emit_exp(input int idx, input bit last);
      return {1'b1, 1'b0, 1'b1, 1'b0, last, 4'(idx)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [N-1:0] b);
      load_valid = 1'b1;
      load_bits  = b;
      step();
      load_valid = 1'b0;
      load_bits  = 16'(~b);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs, IDLE_EXP);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sparse();
      int idx [4] = '{0, 5, 10, 15};
      out_ready = 1'b1;
      load(16'h8421);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs !== emit_exp(idx[k], k == 3)) begin
            errors++;
            $display("[TB] FAIL sparse_emit%0d: got %h expected %h", k, obs, emit_exp(idx[k], k == 3));
         end
         step();
      end
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL sparse_idle: got %h expected %h", obs, IDLE_EXP);
      end
   endtask

   task automatic test_empty();
      out_ready = 1'b1;
      load(16'h0000);
      checks++;
      if (obs !== EMPTY_EXP) begin
         errors++;
         $display("[TB] FAIL empty_pulse: got %h expected %h", obs, EMPTY_EXP);
      end
      step();
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL empty_idle: got %h expected %h", obs, IDLE_EXP);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      load(16'h0006);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs !== emit_exp(1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL stall_hold%0d: got %h expected %h", k, obs, emit_exp(1, 1'b0));
         end
         step();
      end
      out_ready = 1'b1;
      checks++;
      if (obs !== emit_exp(1, 1'b0)) begin
         errors++;
         $display("[TB] FAIL stall_first: got %h expected %h", obs, emit_exp(1, 1'b0));
      end
      step();
      checks++;
      if (obs !== emit_exp(2, 1'b1)) begin
         errors++;
         $display("[TB] FAIL stall_last: got %h expected %h", obs, emit_exp(2, 1'b1));
      end
      step();
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL stall_idle: got %h expected %h", obs, IDLE_EXP);
      end
   endtask

   task automatic test_all_ones();
      out_ready = 1'b1;
      load(16'hFFFF);
      for (int k = 0; k < N; k++) begin
         checks++;
         if (obs !== emit_exp(k, k == N - 1)) begin
            errors++;
            $display("[TB] FAIL ones_emit%0d: got %h expected %h", k, obs, emit_exp(k, k == N - 1));
         end
         step();
      end
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL ones_idle: got %h expected %h", obs, IDLE_EXP);
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      load(16'h00F0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs !== emit_exp(4 + k, 1'b0)) begin
            errors++;
            $display("[TB] FAIL midrst_emit%0d: got %h expected %h", k, obs, emit_exp(4 + k, 1'b0));
         end
         step();
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL midrst_async: got %h expected %h", obs, IDLE_EXP);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL midrst_after: got %h expected %h", obs, IDLE_EXP);
      end
      load(16'h0001);
      checks++;
      if (obs !== emit_exp(0, 1'b1)) begin
         errors++;
         $display("[TB] FAIL midrst_reload: got %h expected %h", obs, emit_exp(0, 1'b1));
      end
      step();
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL midrst_idle: got %h expected %h", obs, IDLE_EXP);
      end
   endtask

   task automatic test_clear();
      out_ready = 1'b0;
      load(16'h0300);
      checks++;
      if (obs !== emit_exp(8, 1'b0)) begin
         errors++;
         $display("[TB] FAIL clear_emit: got %h expected %h", obs, emit_exp(8, 1'b0));
      end
      clear     = 1'b1;
      out_ready = 1'b1;
      step();
      clear     = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL clear_idle: got %h expected %h", obs, IDLE_EXP);
      end
      // A load presented together with clear must not be captured.
      clear      = 1'b1;
      load_valid = 1'b1;
      load_bits  = 16'h0300;
      step();
      clear      = 1'b0;
      load_valid = 1'b0;
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("[TB] FAIL clear_blocks_load: got %h expected %h", obs, IDLE_EXP);
      end
      out_ready = 1'b1;
      load(16'h0300);
      checks++;
      if (obs !== emit_exp(8, 1'b0)) begin
         errors++;
         $display("[TB] FAIL clear_reload8: got %h expected %h", obs, emit_exp(8, 1'b0));
      end
      step();
      checks++;
      if (obs !== emit_exp(9, 1'b1)) begin
         errors++;
         $display("[TB] FAIL clear_reload9: got %h expected %h", obs, emit_exp(9, 1'b1));
      end
      step();
   endtask

   task automatic test_random();
      logic [N-1:0] b;
      int           cycles;
      bit           rdy;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = 16'(1) << $urandom_range(0, N - 1);
            2:       b = 16'($urandom);
            default: b = 16'($urandom) & 16'($urandom) & 16'($urandom);
         endcase
         build_model(b);
         load(b);
         if (exp_q.size() == 0) begin
            checks++;
            if (obs !== EMPTY_EXP) begin
               errors++;
               $display("[TB] FAIL rand_empty b=%h: got %h expected %h", b, obs, EMPTY_EXP);
            end
            step();
         end else begin
            cycles = 0;
            while (exp_q.size() > 0 && cycles < 200) begin
               checks++;
               if (obs !== emit_exp(exp_q[0], exp_q.size() == 1)) begin
                  errors++;
                  $display("[TB] FAIL rand_emit b=%h: got %h expected %h", b, obs, emit_exp(exp_q[0], exp_q.size() == 1));
               end
               rdy       = 1'($urandom_range(0, 1));
               out_ready = rdy;
               load_bits = 16'($urandom);
               step();
               if (rdy) void'(exp_q.pop_front());
               cycles++;
            end
            if (exp_q.size() != 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL rand_timeout b=%h: remaining %0d expected 0", b, exp_q.size());
               exp_q.delete();
            end
         end
         checks++;
         if (obs !== IDLE_EXP) begin
            errors++;
            $display("[TB] FAIL rand_idle b=%h: got %h expected %h", b, obs, IDLE_EXP);
         end
      end
   endtask

   // Scenario sequence and final summary.
   initial begin
      errors     = 0;
      checks     = 0;
      rst_n      = 1'b0;
      clear      = 1'b0;
      load_valid = 1'b0;
      load_bits  = '0;
      out_ready  = 1'b0;
      test_reset();
      test_sparse();
      test_empty();
      test_backpressure();
      test_all_ones();
      test_reset_midstream();
      test_clear();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
